servo_pulse_decoder: RTL and testbench
======================================

SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 SHALL take parameter CLKS_PER_US, default 25, system clocks per microsecond (25 MHz CLK).
REQ-002 SHALL take parameter TIMEOUT_US, default 25000, the no-edge interval in µs after which the signal is declared lost.
REQ-003 SHALL take parameters MIN_US, default 1000, and MAX_US, default 2000, the inclusive legal pulse-width window.
REQ-004 SHALL have port CLK  input  1  system clock; the block uses one clock and all logic runs on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; reset is synchronous and active-high.
REQ-006 SHALL have port PWM_IN  input  1  asynchronous servo PWM signal from a PMOD pin.
REQ-007 SHALL have port width_us  output  16  high time of the last complete frame, in µs.
REQ-008 SHALL have port period_us  output  16  rise-to-rise period of the last complete frame, in µs.
REQ-009 SHALL have port valid  output  1  one-cycle strobe that marks new width_us and period_us values.
REQ-010 SHALL have port in_range  output  1  set when MIN_US <= width_us <= MAX_US.
REQ-011 SHALL have port signal_lost  output  1  level flag for no edge within TIMEOUT_US.

Function
REQ-012 SHALL pass PWM_IN through a two-flop synchronizer, plus one edge-detect register; rise and fall are single-cycle events on the synchronized signal.
REQ-013 SHALL use a prescaler counting 0..CLKS_PER_US-1 that emits a µs tick at CLKS_PER_US-1; the prescaler SHALL be cleared on every detected edge.
REQ-014 SHALL keep width_cnt and period_cnt, both 16 bits; each increments on a tick and saturates at 16'hFFFF with no wrap.
REQ-015 SHALL reported values equal floor(edge-to-edge clocks / CLKS_PER_US).
REQ-016 SHALL implement FSM states ARM, WAIT_RISE, HIGH and LOW.
REQ-017 ARM: when the synchronized input is low -> WAIT_RISE with counters cleared; this discards any partial pulse seen at start-up.
REQ-018 WAIT_RISE: rise -> HIGH with both counters cleared; this first rise SHALL NOT produce valid.
REQ-019 HIGH: fall -> LOW; width_cnt is latched into an internal width register; period_cnt keeps running.
REQ-020 LOW: rise -> HIGH, with valid=1 on the next cycle, width_us = latched width, period_us = period_cnt, in_range updated in the same cycle, and both counters cleared.
REQ-021 SHALL measure the total latency from a PWM_IN rise to the valid strobe as 4 clocks: 2 synchronizer, 1 edge detect, 1 output register.
REQ-022 Timeout: in WAIT_RISE, HIGH or LOW, when the running count reaches TIMEOUT_US -> signal_lost=1 and next state ARM; width_us and period_us hold their old values and no valid is issued.
REQ-023 SHALL clear signal_lost in the same cycle that valid is asserted.
REQ-024 SHALL let a rise and a timeout that occur in the same cycle resolve in favour of the edge.
REQ-025 SHALL hold width_us, period_us and in_range between valid strobes.
REQ-026 SHALL never assert valid on two consecutive cycles; the minimum spacing between strobes is one period.

Reset
REQ-027 SHALL, while RST=1 on a rising CLK edge, set state=ARM, counters=0, prescaler=0, synchronizer=0, width_us=0, period_us=0, valid=0, in_range=0 and signal_lost=1.
REQ-028 SHALL, on a reset asserted mid-frame, abandon the frame; the first valid after release requires ARM -> WAIT_RISE -> one full HIGH/LOW frame.

Structure
REQ-029 SHALL take CLKS_PER_US, SERVO_MIN_US=1000, SERVO_MAX_US=2000, SERVO_CENTER_US=1500 and SERVO_TIMEOUT_US=25000 from shared package servo_pkg, which the servo PWM generator also uses.
REQ-030 SHALL place the prescaler in sub-module us_prescaler, with ports CLK, RST, clr and tick.
REQ-031 SHALL keep the FSM, counters and output registers in servo_pulse_decoder.

Verification
REQ-032 Drive frames of 1500 µs high in a 20000 µs period -> first rise yields no valid; each later rise yields valid, width_us=1500, period_us=20000, in_range=1, signal_lost=0.
REQ-033 Drive a 800 µs high frame, then a 2200 µs high frame -> width_us=800 then 2200, in_range=0 for both; then a 2000 µs frame -> in_range=1, which checks the inclusive upper bound.
REQ-034 Hold PWM_IN low for 30 ms after lock -> signal_lost=1 exactly 25000 µs (+4 clk) after the last rise, with no valid; resumed frames clear signal_lost on the second rise.
REQ-035 Hold PWM_IN high for 30 ms -> signal_lost=1, FSM in ARM; no valid until a low, a rise, and one full frame occur.
REQ-036 Assert RST for 1 cycle midway through a 1500 µs high pulse -> outputs return to reset values; the pulse in progress produces no valid.
REQ-037 Release reset with PWM_IN already high -> the partial pulse is ignored; the first valid reports a full-frame width of 1500 µs.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo constants and helpers, used by both the PWM generator and
// the pulse decoder so that timing limits stay consistent across the two.
package servo_pkg;

    localparam int CLKS_PER_US      = 25;
    localparam int SERVO_MIN_US     = 1000;
    localparam int SERVO_MAX_US     = 2000;
    localparam int SERVO_CENTER_US  = 1500;
    localparam int SERVO_TIMEOUT_US = 25000;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Decoder frame-tracking states
    typedef enum logic [1:0] {
        ST_ARM,
        ST_WAIT_RISE,
        ST_HIGH,
        ST_LOW
    } dec_state_e;

    // Saturating increment: a counter that would wrap sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/us_prescaler.sv
// Microsecond prescaler: counts 0..CLKS_PER_US-1 and flags the last count as
// a one-clock tick. A clear restarts the count so a new microsecond begins
// on the clear edge.
module us_prescaler #(
    parameter int CLKS_PER_US = servo_pkg::CLKS_PER_US
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on clear or at the end of each microsecond
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM pulse decoder: measures the high time and rise-to-rise period of
// each complete frame in microseconds, flags widths inside the legal window
// and declares the signal lost when no edge arrives within the timeout.
module servo_pulse_decoder #(
    parameter int CLKS_PER_US = servo_pkg::CLKS_PER_US,
    parameter int TIMEOUT_US  = servo_pkg::SERVO_TIMEOUT_US,
    parameter int MIN_US      = servo_pkg::SERVO_MIN_US,
    parameter int MAX_US      = servo_pkg::SERVO_MAX_US
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PWM_IN,
    output logic [15:0] width_us,
    output logic [15:0] period_us,
    output logic        valid,
    output logic        in_range,
    output logic        signal_lost
);

    import servo_pkg::*;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_US);
    localparam logic [15:0] MIN_W       = 16'(MIN_US);
    localparam logic [15:0] MAX_W       = 16'(MAX_US);

    // Input conditioning
    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;
    logic [1:0] prime_q;
    logic       primed;

    // Measurement and output state
    dec_state_e  state_q;
    logic [15:0] width_cnt_q;
    logic [15:0] period_cnt_q;
    logic [15:0] width_lat_q;
    logic [15:0] width_q;
    logic [15:0] period_q;
    logic        valid_q;
    logic        in_range_q;
    logic        lost_q;

    logic        tick;
    logic        pre_clr;
    logic        arm_exit;
    logic        timeout;
    logic        width_in_window;
    logic [15:0] width_inc;
    logic [15:0] period_inc;

    // Two-flop synchronizer followed by a registered edge detector; the prime
    // counter marks when level_q reflects the pin rather than reset zeros.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            sync1_q <= PWM_IN;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            rise_q  <= sync2_q & ~level_q;
            fall_q  <= ~sync2_q & level_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign primed = (prime_q == 2'd3);

    // Leaving ARM restarts the microsecond grid along with the counters, so
    // the wait-for-rise timeout starts on a whole-microsecond boundary.
    assign arm_exit = (state_q == ST_ARM) && primed && !level_q;
    assign pre_clr  = rise_q | fall_q | arm_exit;

    us_prescaler #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .clr (pre_clr),
        .tick(tick)
    );

    // Counts including this cycle's tick, so a value reported on an edge
    // equals floor(edge-to-edge clocks / CLKS_PER_US).
    assign width_inc       = sat_inc(width_cnt_q, tick);
    assign period_inc      = sat_inc(period_cnt_q, tick);
    assign timeout         = (period_inc >= TIMEOUT_CNT);
    assign width_in_window = (width_lat_q >= MIN_W) && (width_lat_q <= MAX_W);

    // Frame tracking FSM with counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_ARM;
            width_cnt_q  <= '0;
            period_cnt_q <= '0;
            width_lat_q  <= '0;
            width_q      <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            in_range_q   <= 1'b0;
            lost_q       <= 1'b1;
        end else begin
            valid_q      <= 1'b0;
            width_cnt_q  <= width_inc;
            period_cnt_q <= period_inc;
            case (state_q)
                ST_ARM: begin
                    // Stay here until the pin is seen low so a pulse already
                    // in progress is never measured.
                    width_cnt_q  <= '0;
                    period_cnt_q <= '0;
                    if (arm_exit) begin
                        state_q <= ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    // First rise only starts a frame; nothing to report yet.
                    if (rise_q) begin
                        width_cnt_q  <= '0;
                        period_cnt_q <= '0;
                        state_q      <= ST_HIGH;
                    end else if (timeout) begin
                        lost_q  <= 1'b1;
                        state_q <= ST_ARM;
                    end
                end
                ST_HIGH: begin
                    if (timeout) begin
                        lost_q  <= 1'b1;
                        state_q <= ST_ARM;
                    end else if (fall_q) begin
                        width_lat_q <= width_inc;
                        state_q     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    // A rise closes the frame; it wins over a same-cycle timeout.
                    if (rise_q) begin
                        valid_q      <= 1'b1;
                        width_q      <= width_lat_q;
                        period_q     <= period_inc;
                        in_range_q   <= width_in_window;
                        lost_q       <= 1'b0;
                        width_cnt_q  <= '0;
                        period_cnt_q <= '0;
                        state_q      <= ST_HIGH;
                    end else if (timeout) begin
                        lost_q  <= 1'b1;
                        state_q <= ST_ARM;
                    end
                end
                default: begin
                    state_q <= ST_ARM;
                end
            endcase
        end
    end

    assign width_us    = width_q;
    assign period_us   = period_q;
    assign valid       = valid_q;
    assign in_range    = in_range_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Testbench for servo_pulse_decoder with scaled-down timing (4 clocks per us,
// 10..20 us window, 250 us timeout). Stimulus pushes expected events into a
// queue via an edge-level reference model; a monitor compares DUT outputs.
module tb_servo_pulse_decoder;

    localparam int C    = 4;
    localparam int T    = 250;
    localparam int MINU = 10;
    localparam int MAXU = 20;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PWM_IN;
    logic [15:0] width_us;
    logic [15:0] period_us;
    logic        valid;
    logic        in_range;
    logic        signal_lost;

    servo_pulse_decoder #(
        .CLKS_PER_US(C),
        .TIMEOUT_US (T),
        .MIN_US     (MINU),
        .MAX_US     (MAXU)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PWM_IN     (PWM_IN),
        .width_us   (width_us),
        .period_us  (period_us),
        .valid      (valid),
        .in_range   (in_range),
        .signal_lost(signal_lost)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit is_lost;
        int cyc;
        int w;
        int p;
        bit inr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   rst_mask = 1'b1;

    // Reference model: 0 = needs a low level, 1 = waiting first rise, 2 = tracking
    int m_mode  = 0;
    int m_rise  = 0;
    int m_fall  = 0;
    bit m_has_fall = 1'b0;
    bit m_level = 1'b0;
    int m_w = 0;
    int m_p = 0;
    bit m_inr = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_exp(bit is_lost, int c, int w, int p, bit inr);
        exp_t e;
        e.is_lost = is_lost;
        e.cyc     = c;
        e.w       = w;
        e.p       = p;
        e.inr     = inr;
        exp_q.push_back(e);
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // If the next edge can only come at 'limit', decide whether the frame
    // started by the last rise has already timed out.
    function automatic void model_advance(int limit);
        if (m_mode == 2 && (limit - m_rise) > T * C) begin
            push_exp(1'b1, m_rise + 3 + T * C, m_w, m_p, m_inr);
            m_mode = m_level ? 0 : 1;
        end
    endfunction

    // PWM edge first sampled on rising edge t
    function automatic void model_edge(int t, bit lvl);
        model_advance(t);
        if (lvl && !m_level) begin
            if (m_mode == 2) begin
                if (m_has_fall) begin
                    m_w   = sat16((m_fall - m_rise) / C);
                    m_p   = sat16((t - m_rise) / C);
                    m_inr = (m_w >= MINU) && (m_w <= MAXU);
                    push_exp(1'b0, t + 3, m_w, m_p, m_inr);
                end
                m_rise     = t;
                m_has_fall = 1'b0;
            end else if (m_mode == 1) begin
                m_mode     = 2;
                m_rise     = t;
                m_has_fall = 1'b0;
            end
        end else if (!lvl && m_level) begin
            if (m_mode == 2 && !m_has_fall) begin
                m_fall     = t;
                m_has_fall = 1'b1;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end
        end
        m_level = lvl;
    endfunction

    task automatic drive(bit lvl, int hold);
        int t;
        @(negedge CLK);
        t = cyc + 1;
        PWM_IN = lvl;
        model_edge(t, lvl);
        model_advance(t + hold);
        repeat (hold - 1) @(negedge CLK);
    endtask

    task automatic frame(int w, int p);
        drive(1'b1, w * C);
        drive(1'b0, (p - w) * C);
    endtask

    task automatic do_reset(int cycles);
        @(negedge CLK);
        model_advance(cyc + 1);
        chk("queue_empty_before_reset", exp_q.size(), 0);
        exp_q.delete();
        rst_mask = 1'b1;
        RST = 1'b1;
        repeat (cycles) @(negedge CLK);
        chk("rst_width_us", int'(width_us), 0);
        chk("rst_period_us", int'(period_us), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_in_range", int'(in_range), 0);
        chk("rst_signal_lost", int'(signal_lost), 1);
        m_mode     = m_level ? 0 : 1;
        m_has_fall = 1'b0;
        m_w        = 0;
        m_p        = 0;
        m_inr      = 1'b0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        rst_mask = 1'b0;
    endtask

    // Monitor: compare every valid strobe and every rise of signal_lost
    initial begin
        bit   prev_valid = 1'b0;
        bit   prev_lost  = 1'b1;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (valid) begin
                $display("valid  @%0d width_us=%0d period_us=%0d in_range=%0d lost=%0d",
                         cyc, width_us, period_us, in_range, signal_lost);
                chk("valid_spacing", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_valid: got valid at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (e.is_lost) begin
                        n_err++;
                        $display("FAIL event_kind: got valid at cycle %0d, required signal_lost at %0d", cyc, e.cyc);
                    end else begin
                        chk("valid_cycle", cyc, e.cyc);
                        chk("width_us", int'(width_us), e.w);
                        chk("period_us", int'(period_us), e.p);
                        chk("in_range", int'(in_range), int'(e.inr));
                        chk("lost_cleared", int'(signal_lost), 0);
                    end
                end
            end
            if (!rst_mask && signal_lost && !prev_lost) begin
                $display("lost   @%0d width_us=%0d period_us=%0d in_range=%0d",
                         cyc, width_us, period_us, in_range);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_lost: got signal_lost at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (!e.is_lost) begin
                        n_err++;
                        $display("FAIL event_kind: got signal_lost at cycle %0d, required valid at %0d", cyc, e.cyc);
                    end else begin
                        chk("lost_cycle", cyc, e.cyc);
                        chk("lost_hold_width", int'(width_us), e.w);
                        chk("lost_hold_period", int'(period_us), e.p);
                        chk("lost_hold_in_range", int'(in_range), int'(e.inr));
                        chk("lost_no_valid", int'(valid), 0);
                    end
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL missing_event: got nothing by cycle %0d, required %s at cycle %0d",
                         cyc, exp_q[0].is_lost ? "signal_lost" : "valid", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            prev_valid = valid;
            prev_lost  = signal_lost;
        end
    end

    // Stimulus
    initial begin
        int w;
        int p;
        RST    = 1'b1;
        PWM_IN = 1'b0;
        do_reset(3);
        drive(1'b0, 20 * C);

        // Nominal frames: first rise silent, later rises report 15/200
        repeat (5) frame(15, 200);

        // Out-of-window and boundary widths
        frame(8, 200);
        frame(22, 200);
        frame(20, 200);
        frame(10, 200);
        frame(9, 200);
        frame(21, 200);

        // Randomized frames within the timeout
        repeat (16) begin
            p = $urandom_range(40, 250);
            w = $urandom_range(1, 30);
            frame(w, p);
        end

        // Period exactly at the timeout (edge wins), then one microsecond over
        frame(15, 250);
        frame(15, 251);
        frame(15, 200);
        frame(15, 200);

        // Input stuck low after lock, then recovery
        drive(1'b1, 15 * C);
        drive(1'b0, 300 * C);
        repeat (3) frame(15, 200);

        // Input stuck high, then recovery
        drive(1'b1, 300 * C);
        drive(1'b0, 50 * C);
        repeat (3) frame(15, 200);

        // Reset in the middle of a high pulse, released with the pin high
        drive(1'b1, 7 * C);
        do_reset(1);
        drive(1'b1, 8 * C);
        drive(1'b0, 185 * C);
        repeat (3) frame(15, 200);

        repeat (20) @(negedge CLK);
        chk("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
